// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK_A = 3'd3,
    WRITE = 3'd4,
    READ  = 3'd5,
    ACK_D = 3'd6,
    STOP  = 3'd7
  } i2c_state_t;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } i2c_qtr_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_qtr_tick.sv
// SCL quarter-period timebase; counts only while running and freezes on hold.
module i2c_qtr_tick #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic hold,
  output logic tick
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] CNT_MAX = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + DIV_W'(1);
    end
  end

  assign tick = run && !hold && (cnt == CNT_MAX);

endmodule

// File: rtl/i2c_master_xfer.sv
// I2C master running one START/addr/data/STOP transaction per request,
// with internal SCL timebase, clock-stretch support and open-drain controls.
module i2c_master_xfer
  import i2c_pkg::*;
#(
  parameter  int unsigned CLK_DIV   = 250,
  parameter  int unsigned MAX_BYTES = 4,
  localparam int unsigned CNT_W     = $clog2(MAX_BYTES + 1),
  localparam int unsigned DATA_W    = 8 * MAX_BYTES
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rw,
  input  logic [6:0]        addr,
  input  logic [CNT_W-1:0]  nbytes,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              nack,
  output logic              scl_oe,
  output logic              sda_oe,
  input  logic              scl_i,
  input  logic              sda_i
);

  i2c_state_t        state, state_n;
  i2c_qtr_t          qtr, qtr_n;
  logic [2:0]        bit_idx, bit_idx_n;
  logic [CNT_W-1:0]  byte_idx, byte_idx_n;
  logic [6:0]        addr_q, addr_n;
  logic              rw_q, rw_n;
  logic [CNT_W-1:0]  nbytes_q, nbytes_n;
  logic [DATA_W-1:0] wdata_q, wdata_n;
  logic [7:0]        rx_byte, rx_byte_n;
  logic [DATA_W-1:0] rdata_n;
  logic              busy_n, done_n, nack_n;
  logic              scl_oe_n, sda_oe_n;
  logic              q3_first, q3_first_n;
  logic              sda_smp, sda_smp_n;
  logic              smp_bit;
  logic              tick;
  logic              scl_hold;
  logic [7:0]        tx_byte;
  logic              last_byte;
  logic              master_ack;
  logic              lo_half;

  // A slave holding SCL low during the released phase stalls the timebase
  assign scl_hold = (qtr == Q2) && !scl_i;

  i2c_qtr_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_qtr_tick (
    .clk   (clk),
    .reset (reset),
    .run   (busy),
    .hold  (scl_hold),
    .tick  (tick)
  );

  // SDA is captured on the first Q3 cycle; bypass keeps it valid when Q3 is one cycle
  assign smp_bit = q3_first ? sda_i : sda_smp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      qtr      <= Q0;
      bit_idx  <= '0;
      byte_idx <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      nbytes_q <= '0;
      wdata_q  <= '0;
      rx_byte  <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      nack     <= 1'b0;
      scl_oe   <= 1'b0;
      sda_oe   <= 1'b0;
      q3_first <= 1'b0;
      sda_smp  <= 1'b0;
    end else begin
      state    <= state_n;
      qtr      <= qtr_n;
      bit_idx  <= bit_idx_n;
      byte_idx <= byte_idx_n;
      addr_q   <= addr_n;
      rw_q     <= rw_n;
      nbytes_q <= nbytes_n;
      wdata_q  <= wdata_n;
      rx_byte  <= rx_byte_n;
      rdata    <= rdata_n;
      busy     <= busy_n;
      done     <= done_n;
      nack     <= nack_n;
      scl_oe   <= scl_oe_n;
      sda_oe   <= sda_oe_n;
      q3_first <= q3_first_n;
      sda_smp  <= sda_smp_n;
    end
  end

  always_comb begin
    state_n    = state;
    qtr_n      = qtr;
    bit_idx_n  = bit_idx;
    byte_idx_n = byte_idx;
    addr_n     = addr_q;
    rw_n       = rw_q;
    nbytes_n   = nbytes_q;
    wdata_n    = wdata_q;
    rx_byte_n  = rx_byte;
    rdata_n    = rdata;
    busy_n     = busy;
    done_n     = 1'b0;
    nack_n     = nack;
    q3_first_n = tick && (qtr == Q2);
    sda_smp_n  = smp_bit;
    tx_byte    = {addr_q, rw_q};
    last_byte  = 1'b0;
    master_ack = I2C_ACK;
    lo_half    = 1'b0;
    scl_oe_n   = 1'b0;
    sda_oe_n   = 1'b0;

    if (state == IDLE) begin
      if (start) begin
        state_n    = START;
        qtr_n      = Q0;
        bit_idx_n  = '0;
        byte_idx_n = '0;
        addr_n     = addr;
        rw_n       = rw;
        nbytes_n   = (nbytes > CNT_W'(MAX_BYTES)) ? CNT_W'(MAX_BYTES) : nbytes;
        wdata_n    = wdata;
        busy_n     = 1'b1;
        nack_n     = 1'b0;
      end
    end else if (tick) begin
      qtr_n = i2c_qtr_t'(qtr + 2'd1);
      // Bit-slot boundary: all state decisions happen at the end of Q3
      if (qtr == Q3) begin
        case (state)
          START: begin
            state_n   = ADDR;
            bit_idx_n = '0;
          end
          ADDR: begin
            if (bit_idx == 3'd7) state_n = ACK_A;
            else bit_idx_n = bit_idx + 3'd1;
          end
          ACK_A: begin
            bit_idx_n = '0;
            if (smp_bit == I2C_NACK) begin
              nack_n  = 1'b1;
              state_n = STOP;
            end else if (nbytes_q == '0) begin
              state_n = STOP;
            end else begin
              state_n = rw_q ? READ : WRITE;
            end
          end
          WRITE: begin
            if (bit_idx == 3'd7) state_n = ACK_D;
            else bit_idx_n = bit_idx + 3'd1;
          end
          READ: begin
            rx_byte_n = {rx_byte[6:0], smp_bit};
            if (bit_idx == 3'd7) begin
              for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                if (CNT_W'(i) == byte_idx) rdata_n[8*i +: 8] = rx_byte_n;
              end
              state_n = ACK_D;
            end else begin
              bit_idx_n = bit_idx + 3'd1;
            end
          end
          ACK_D: begin
            bit_idx_n = '0;
            if (!rw_q && (smp_bit == I2C_NACK)) begin
              nack_n  = 1'b1;
              state_n = STOP;
            end else begin
              byte_idx_n = byte_idx + CNT_W'(1);
              if (byte_idx_n == nbytes_q) state_n = STOP;
              else state_n = rw_q ? READ : WRITE;
            end
          end
          STOP: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
          default: state_n = IDLE;
        endcase
      end
    end

    // Line drive follows the state/quarter being entered
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if ((state_n == WRITE) && (CNT_W'(i) == byte_idx_n)) tx_byte = wdata_q[8*i +: 8];
    end
    last_byte  = (byte_idx_n == CNT_W'(nbytes_q - CNT_W'(1)));
    master_ack = last_byte ? I2C_NACK : I2C_ACK;
    lo_half    = (qtr_n == Q0) || (qtr_n == Q1);

    case (state_n)
      START: sda_oe_n = 1'b1;
      ADDR, WRITE: begin
        scl_oe_n = lo_half;
        sda_oe_n = ~tx_byte[~bit_idx_n];
      end
      ACK_A, READ: scl_oe_n = lo_half;
      ACK_D: begin
        scl_oe_n = lo_half;
        sda_oe_n = rw_q && (master_ack == I2C_ACK);
      end
      STOP: begin
        scl_oe_n = (qtr_n == Q0);
        sda_oe_n = (qtr_n != Q3);
      end
      default: begin
        scl_oe_n = 1'b0;
        sda_oe_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_xfer.sv
// Bench for i2c_master_xfer: open-drain bus, slave model and frame scoreboard.
module tb_i2c_master_xfer;

  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned MAX_BYTES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic [6:0]  addr;
  logic [2:0]  nbytes;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy, done, nack, scl_oe, sda_oe;
  logic        scl, sda;

  logic        s_scl_hold = 1'b0;
  logic        s_sda_low  = 1'b0;

  assign scl = ~(scl_oe | s_scl_hold);
  assign sda = ~(sda_oe | s_sda_low);

  i2c_master_xfer #(
    .CLK_DIV   (CLK_DIV),
    .MAX_BYTES (MAX_BYTES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .rw     (rw),
    .addr   (addr),
    .nbytes (nbytes),
    .wdata  (wdata),
    .rdata  (rdata),
    .busy   (busy),
    .done   (done),
    .nack   (nack),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe),
    .scl_i  (scl),
    .sda_i  (sda)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard of {byte, ack} frames expected on the bus
  logic [8:0] exp_frames[$];

  // Slave model configuration and state
  int         nack_frame = -1;
  logic       stretch_en = 1'b0;
  logic [7:0] rd_bytes[4];
  int         bit_cnt = 0;
  int         frame_idx = 0;
  int         hold_left = 0;
  logic [7:0] sh = '0;
  logic       is_read = 1'b0;
  logic       rd_done = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         n_start = 0;
  int         n_stop = 0;

  always @(negedge clk) begin
    logic [8:0] e;
    if (s_scl_hold) begin
      hold_left--;
      if (hold_left == 0) s_scl_hold = 1'b0;
    end
    if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b1 && sda === 1'b0) begin
      n_start++;
      bit_cnt = 0; frame_idx = 0; is_read = 1'b0; rd_done = 1'b0; s_sda_low = 1'b0;
    end else if (prev_scl === 1'b1 && scl === 1'b1 && prev_sda === 1'b0 && sda === 1'b1) begin
      n_stop++;
      bit_cnt = 0; frame_idx = 0; s_sda_low = 1'b0;
    end else if (prev_scl === 1'b0 && scl === 1'b1) begin
      if (bit_cnt < 8) begin
        sh = {sh[6:0], sda};
        if (frame_idx == 0 && bit_cnt == 7) is_read = sda;
        bit_cnt++;
      end else begin
        if (exp_frames.size() == 0) begin
          check_val("frame_unexpected", 32'(exp_frames.size()), 32'd1);
        end else begin
          e = exp_frames.pop_front();
          check_val("frame", 32'({sh, sda}), 32'(e));
        end
        if (is_read && frame_idx > 0 && sda === 1'b1) rd_done = 1'b1;
        frame_idx++;
        bit_cnt = 0;
      end
    end else if (prev_scl === 1'b1 && scl === 1'b0) begin
      if (bit_cnt == 8 && (frame_idx == 0 || !is_read))
        s_sda_low = (frame_idx != nack_frame);
      else if (is_read && frame_idx > 0 && frame_idx <= 4 && !rd_done && bit_cnt < 8)
        s_sda_low = ~rd_bytes[frame_idx-1][7-bit_cnt];
      else
        s_sda_low = 1'b0;
      if (stretch_en && frame_idx == 0 && bit_cnt == 3) begin
        s_scl_hold = 1'b1;
        hold_left  = 2 * CLK_DIV + 20;
      end
    end
    prev_scl = scl;
    prev_sda = sda;
  end

  task automatic push_frame(input logic [7:0] b, input logic ack);
    exp_frames.push_back({b, ack});
  endtask

  // Run one transaction; poke>=0 pulses a conflicting start that many cycles in
  task automatic do_xfer(input string tag, input logic r, input logic [6:0] a,
                         input logic [2:0] nb, input logic [31:0] wd,
                         input int exp_lat, input logic exp_nack, input int poke);
    int t0;
    int guard;
    @(negedge clk);
    rw = r; addr = a; nbytes = nb; wdata = wd; start = 1'b1;
    n_start = 0; n_stop = 0;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, "_busy"}, 32'(busy), 32'd1);
    check_val({tag, "_nack_clr"}, 32'(nack), 32'd0);
    t0 = cyc;
    guard = 0;
    while (done !== 1'b1 && guard < 4000) begin
      start = (guard == poke);
      addr  = (guard == poke) ? ~a : a;
      rw    = (guard == poke) ? ~r : r;
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    check_val({tag, "_done"}, 32'(done), 32'd1);
    check_val({tag, "_lat"}, 32'(cyc - t0), 32'(exp_lat));
    check_val({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check_val({tag, "_nack"}, 32'(nack), 32'(exp_nack));
    repeat (2) @(negedge clk);
    check_val({tag, "_frames_left"}, 32'(exp_frames.size()), 32'd0);
    check_val({tag, "_starts"}, 32'(n_start), 32'd1);
    check_val({tag, "_stops"}, 32'(n_stop), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; nbytes = '0; wdata = '0;
    rd_bytes[0] = 8'h12; rd_bytes[1] = 8'h34; rd_bytes[2] = 8'h56; rd_bytes[3] = 8'h00;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_nack", 32'(nack), 32'd0);
    check_val("rst_scl_oe", 32'(scl_oe), 32'd0);
    check_val("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Write two bytes, all ACK
    push_frame(8'hA0, 1'b0); push_frame(8'hAA, 1'b0); push_frame(8'h55, 1'b0);
    do_xfer("wr2", 1'b0, 7'h50, 3'd2, 32'h0000_55AA, 464, 1'b0, -1);

    // Read three bytes; master ACK, ACK, NACK
    push_frame(8'hA1, 1'b0); push_frame(8'h12, 1'b0);
    push_frame(8'h34, 1'b0); push_frame(8'h56, 1'b1);
    do_xfer("rd3", 1'b1, 7'h50, 3'd3, 32'h0, 4 * (8 + 36 * 4), 1'b0, -1);
    check_val("rd3_rdata", {8'h0, rdata[23:0]}, 32'h0056_3412);

    // Address probe NACKed
    nack_frame = 0;
    push_frame(8'h78, 1'b1);
    do_xfer("probe_nack", 1'b0, 7'h3C, 3'd0, 32'h0, 176, 1'b1, -1);
    repeat (5) @(negedge clk);
    check_val("probe_nack_hold", 32'(nack), 32'd1);
    check_val("rd3_rdata_hold", {8'h0, rdata[23:0]}, 32'h0056_3412);

    // Four-byte write, slave NACKs byte 1, stray start mid-transfer
    nack_frame = 2;
    push_frame(8'hA0, 1'b0); push_frame(8'hAA, 1'b0); push_frame(8'hBB, 1'b1);
    do_xfer("wr_nack", 1'b0, 7'h50, 3'd4, 32'hDDCC_BBAA, 464, 1'b1, 100);
    repeat (10) @(negedge clk);
    check_val("wr_nack_idle", 32'(busy), 32'd0);

    // Clock stretch of 20 cycles on address bit slot 3
    nack_frame = -1;
    stretch_en = 1'b1;
    push_frame(8'hA0, 1'b0); push_frame(8'hC3, 1'b0);
    do_xfer("stretch", 1'b0, 7'h50, 3'd1, 32'h0000_00C3, 4 * (8 + 72) + 20, 1'b0, -1);
    stretch_en = 1'b0;

    // Byte count above MAX_BYTES clamps to four
    push_frame(8'hA0, 1'b0); push_frame(8'h11, 1'b0); push_frame(8'h22, 1'b0);
    push_frame(8'h33, 1'b0); push_frame(8'h44, 1'b0);
    do_xfer("clamp", 1'b0, 7'h50, 3'd7, 32'h4433_2211, 4 * (8 + 36 * 5), 1'b0, -1);

    // Reset during write byte 0 (SCL-low quarter), then a fresh probe
    push_frame(8'hA0, 1'b0);
    @(negedge clk);
    rw = 1'b0; addr = 7'h50; nbytes = 3'd2; wdata = 32'h0000_55AA; start = 1'b1;
    n_start = 0; n_stop = 0;
    @(negedge clk);
    start = 1'b0;
    check_val("abort_busy", 32'(busy), 32'd1);
    repeat (193) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_scl_oe", 32'(scl_oe), 32'd0);
    check_val("abort_sda_oe", 32'(sda_oe), 32'd0);
    check_val("abort_busy_low", 32'(busy), 32'd0);
    check_val("abort_done", 32'(done), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("abort_no_stop", 32'(n_stop), 32'd0);
    check_val("abort_frames_left", 32'(exp_frames.size()), 32'd0);
    push_frame(8'hA0, 1'b0);
    do_xfer("after_abort", 1'b0, 7'h50, 3'd0, 32'h0, 176, 1'b0, -1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
